// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: sequences track/hold, MSB-first
// binary search on the capacitive DAC, and publishes the completed code.
module sar_ctrl #(
    parameter int NBITS         = 10,
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp,
    output logic             sample,
    output logic             cmp_en,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int CNT_W = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SAMPLE = 2'd1;
    localparam logic [1:0] S_CONV   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [NBITS-1:0] MSB_ONLY = {1'b1, {(NBITS-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [NBITS-1:0] conv_code;

    // Resolve the bit under test with the comparator and arm the next trial bit.
    always_comb begin
        conv_code      = dac_code;
        conv_code[idx] = cmp;
        if (idx != '0) begin
            conv_code[idx - IDX_W'(1)] = 1'b1;
        end
    end

    // NOTE: every output is a flop updated alongside the state so the analog
    // core never sees decode glitches; all sequential updates use <= so each
    // edge reads only pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            sample   <= 1'b0;
            cmp_en   <= 1'b0;
            dac_code <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (!en) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            sample   <= 1'b0;
            cmp_en   <= 1'b0;
            dac_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= S_SAMPLE;
                        cnt      <= CNT_W'(SAMPLE_CYCLES - 1);
                        sample   <= 1'b1;
                        dac_code <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (cnt == '0) begin
                        state    <= S_CONV;
                        sample   <= 1'b0;
                        cmp_en   <= 1'b1;
                        dac_code <= MSB_ONLY;
                        idx      <= IDX_W'(NBITS - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_CONV: begin
                    dac_code <= conv_code;
                    if (idx == '0) begin
                        state  <= S_DONE;
                        result <= conv_code;
                        cmp_en <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                default: begin  // S_DONE
                    done     <= 1'b0;
                    dac_code <= '0;
                    if (cont) begin
                        state  <= S_SAMPLE;
                        cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
                        sample <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: ideal comparator model plus a result scoreboard.
module tb_sar_ctrl;

    localparam int NB = 10;
    localparam int SC = 4;
    localparam int LAT = SC + NB + 1;

    logic          clk = 1'b0;
    logic          rst_n, en, start, cont;
    logic          cmp;
    logic          sample, cmp_en, busy, done;
    logic [NB-1:0] dac_code, result;
    logic [NB-1:0] vin;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int exp_q[$];

    sar_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cont(cont), .cmp(cmp),
        .sample(sample), .cmp_en(cmp_en), .dac_code(dac_code), .result(result),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Ideal comparator: 1 when the held input is at or above the DAC trial.
    assign cmp = (vin >= dac_code);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done strobe must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("result", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    // Expected outputs n cycles after the edge that accepted start.
    task automatic expect_cycle(input int n, input int v);
        int b;
        int code;
        bit in_s, in_c, in_d;
        in_s = (n >= 1 && n <= SC);
        in_c = (n > SC && n <= SC + NB);
        in_d = (n == LAT);
        check($sformatf("sample@%0d", n), 32'(sample), 32'(in_s));
        check($sformatf("cmp_en@%0d", n), 32'(cmp_en), 32'(in_c));
        check($sformatf("done@%0d", n), 32'(done), 32'(in_d));
        check($sformatf("busy@%0d", n), 32'(busy), 32'd1);
        if (in_s) check($sformatf("dac_s@%0d", n), 32'(dac_code), 32'd0);
        if (in_c) begin
            b = NB - 1 - (n - SC - 1);
            code = (v & ~((1 << (b + 1)) - 1)) | (1 << b);
            check($sformatf("dac_trial@%0d", n), 32'(dac_code), 32'(code));
        end
    endtask

    task automatic run_checked(input int v, input int first, input int last);
        for (int n = first; n <= last; n++) begin
            expect_cycle(n, v);
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic start_conv(input int v);
        vin = NB'(v);
        start = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sample"}, 32'(sample), 32'd0);
        check({tag, "_cmp_en"}, 32'(cmp_en), 32'd0);
        check({tag, "_dac"}, 32'(dac_code), 32'd0);
    endtask

    task automatic full_conv(input int v);
        start_conv(v);
        run_checked(v, 1, LAT);
        check_idle($sformatf("after_%0h", v));
    endtask

    initial begin
        int dc;
        rst_n = 1'b1; en = 1'b0; start = 1'b0; cont = 1'b0; vin = '0;
        #1 rst_n = 1'b0;
        #1;
        check_idle("reset");
        check("reset_result", 32'(result), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        // No start: must stay idle after reset release.
        repeat (3) @(negedge clk);
        check_idle("post_reset");

        full_conv(10'h2A5);
        full_conv(10'h000);
        full_conv(10'h3FF);

        // Abort with en low during the 5th CONV cycle.
        dc = done_cnt;
        start_conv(10'h123);
        run_checked(10'h123, 1, SC + 4);
        expect_cycle(SC + 5, 10'h123);
        en = 1'b0;
        @(negedge clk);
        check_idle("abort");
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'h3FF);
        void'(exp_q.pop_back());
        en = 1'b1;
        repeat (LAT) @(negedge clk);
        check_idle("abort_settle");
        check("abort_no_done", 32'(done_cnt), 32'(dc));
        check("abort_result_hold", 32'(result), 32'h3FF);

        // start re-pulsed in the 3rd CONV cycle is ignored.
        dc = done_cnt;
        start_conv(10'h0F0);
        run_checked(10'h0F0, 1, SC + 2);
        start = 1'b1;
        run_checked(10'h0F0, SC + 3, SC + 3);
        start = 1'b0;
        run_checked(10'h0F0, SC + 4, LAT);
        repeat (LAT + 5) begin
            check("ignored_start_idle", 32'(busy), 32'd0);
            @(negedge clk);
        end
        check("one_done", 32'(done_cnt), 32'(dc + 1));

        // Continuous mode: two back-to-back conversions, then cont cleared.
        cont = 1'b1;
        start_conv(10'h155);
        run_checked(10'h155, 1, LAT - 1);
        expect_cycle(LAT, 10'h155);
        vin = 10'h0AA;
        exp_q.push_back(10'h0AA);
        @(negedge clk);
        cont = 1'b0;
        run_checked(10'h0AA, 1, LAT);
        check_idle("cont_end");
        check("cont_result", 32'(result), 32'h0AA);

        // Asynchronous reset in the middle of SAMPLE.
        start_conv(10'h1C3);
        run_checked(10'h1C3, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst_release");
        full_conv(10'h1C3);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
